// File: rtl/store_buffer.sv
// store_buffer: posted-store queue with in-order drain engine; loads wait for an empty queue.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_write_data,
    input  logic        core_memwrite,
    input  logic        core_memread,
    input  logic [3:0]  core_sign_mask,
    output logic [31:0] core_read_data,
    output logic        core_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busy
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nx;
    logic [31:0] q_addr [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [3:0]  q_mask [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0] count;
    logic [31:0] hold_addr, hold_data;
    logic [3:0] hold_mask;
    logic is_load, seen_busy, load_done;
    logic full, empty, push, pop, done, issue_st, issue_ld;
    assign full = count == (PTR_W+1)'(DEPTH);
    assign empty = count == '0;
    assign done = state == S_WAIT && seen_busy && !mem_busy;
    assign issue_st = state == S_IDLE && !empty;
    assign issue_ld = state == S_IDLE && empty && core_memread && !load_done;
    // a load in the same slot wins, so a combined request never enqueues a store
    assign push = core_memwrite && !core_memread && !full;
    assign pop = done && !is_load;
    assign core_stall = (core_memwrite && full) | (core_memread && !load_done);
    // request fields are live while issuing, then held from the issue cycle
    always_comb begin
        mem_memwrite = issue_st;
        mem_memread = issue_ld;
        mem_addr = issue_st ? q_addr[rd_ptr] : issue_ld ? core_addr : hold_addr;
        mem_write_data = issue_st ? q_data[rd_ptr] : issue_ld ? core_write_data : hold_data;
        mem_sign_mask = issue_st ? q_mask[rd_ptr] : issue_ld ? core_sign_mask : hold_mask;
        state_nx = (issue_st || issue_ld) ? S_WAIT : done ? S_IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= core_addr;
            q_data[wr_ptr] <= core_write_data;
            q_mask[wr_ptr] <= core_sign_mask;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_mask <= '0;
            is_load <= 1'b0;
            seen_busy <= 1'b0;
            load_done <= 1'b0;
            core_read_data <= '0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (issue_st || issue_ld) begin
                hold_addr <= mem_addr;
                hold_data <= mem_write_data;
                hold_mask <= mem_sign_mask;
                is_load <= issue_ld;
            end
            seen_busy <= state == S_WAIT && !done && (seen_busy || mem_busy);
            load_done <= done && is_load;
            if (done && is_load) core_read_data <= mem_read_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven core ops with a store scoreboard against a 2-cycle-busy memory model.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] core_addr = '0;
    logic [31:0] core_write_data = '0;
    logic        core_memwrite = 1'b0;
    logic        core_memread = 1'b0;
    logic [3:0]  core_sign_mask = '0;
    logic [31:0] core_read_data;
    logic        core_stall;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread, mem_busy;
    logic [3:0]  mem_sign_mask;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_write_data(core_write_data),
        .core_memwrite(core_memwrite), .core_memread(core_memread),
        .core_sign_mask(core_sign_mask), .core_read_data(core_read_data),
        .core_stall(core_stall), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int st_pulses = 0;
    logic [67:0] exp_q [$];

    function automatic void check(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // memory model: busy for two cycles after any request pulse
    logic [31:0] mem_model [logic [31:0]];
    int busy_cnt = 0;
    logic [31:0] rd_q = '0;
    assign mem_busy = busy_cnt != 0;
    assign mem_read_data = rd_q;
    always @(posedge clk) begin
        if (mem_memwrite) mem_model[mem_addr] = mem_write_data;
        if (mem_memread) rd_q <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        if (mem_memwrite || mem_memread) busy_cnt <= 2;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (mem_memwrite) begin
            st_pulses++;
            if (exp_q.size() == 0) check("store_unexpected", {mem_addr, mem_write_data, mem_sign_mask}, 68'h0);
            else check("store_order", {mem_addr, mem_write_data, mem_sign_mask}, exp_q.pop_front());
        end
        if (mem_memread) check("load_after_drain", 68'(exp_q.size()), 68'd0);
    end

    typedef struct {
        logic        ld;
        int          gap;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] rd;
        int          stall;
    } vec_t;
    vec_t tbl [13];

    task automatic op(input vec_t v);
        int n = 0;
        repeat (v.gap) @(negedge clk);
        @(negedge clk);
        core_addr = v.addr;
        core_write_data = v.data;
        core_sign_mask = v.mask;
        core_memwrite = !v.ld;
        core_memread = v.ld;
        #1;
        while (core_stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check(v.ld ? "load_stall" : "store_stall", 68'(n), 68'(v.stall));
        if (v.ld) check("load_data", 68'(core_read_data), 68'(v.rd));
        else exp_q.push_back({v.addr, v.data, v.mask});
        @(posedge clk);
        #1;
        core_memwrite = 1'b0;
        core_memread = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p;
        mem_model[32'h3000] = 32'hCAFEF00D;
        tbl[0]  = '{1'b0, 0,  32'h1004, 32'hDEADBEEF, 4'hF, 32'h0,        0};
        tbl[1]  = '{1'b0, 12, 32'h1008, 32'h11223344, 4'hF, 32'h0,        0};
        tbl[2]  = '{1'b1, 0,  32'h1008, 32'h0,        4'hF, 32'h11223344, 8};
        tbl[3]  = '{1'b1, 4,  32'h3000, 32'h0,        4'hF, 32'hCAFEF00D, 4};
        tbl[4]  = '{1'b0, 12, 32'h2000, 32'h00000001, 4'h1, 32'h0,        0};
        tbl[5]  = '{1'b1, 0,  32'h2000, 32'h0,        4'h1, 32'h00000001, 8};
        tbl[6]  = '{1'b0, 12, 32'h1100, 32'hA0A0A0A0, 4'hF, 32'h0,        0};
        tbl[7]  = '{1'b0, 0,  32'h1104, 32'hB1B1B1B1, 4'h3, 32'h0,        0};
        tbl[8]  = '{1'b0, 0,  32'h1108, 32'hC2C2C2C2, 4'h1, 32'h0,        0};
        tbl[9]  = '{1'b0, 0,  32'h110C, 32'hD3D3D3D3, 4'h7, 32'h0,        0};
        tbl[10] = '{1'b0, 0,  32'h1110, 32'hE4E4E4E4, 4'hB, 32'h0,        1};
        tbl[11] = '{1'b1, 0,  32'h1110, 32'h0,        4'hF, 32'hE4E4E4E4, 19};
        tbl[12] = '{1'b1, 4,  32'h1004, 32'h0,        4'hF, 32'hDEADBEEF, 4};
        repeat (3) @(negedge clk);
        check("rst_memwrite", 68'(mem_memwrite), 68'd0);
        check("rst_memread", 68'(mem_memread), 68'd0);
        check("rst_addr", 68'(mem_addr), 68'd0);
        check("rst_wdata", 68'(mem_write_data), 68'd0);
        check("rst_mask", 68'(mem_sign_mask), 68'd0);
        check("rst_rdata", 68'(core_read_data), 68'd0);
        check("rst_stall", 68'(core_stall), 68'd0);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) op(tbl[i]);
        // interleaved push/pop: each push lands on the cycle the previous entry pops
        p = st_pulses;
        for (int i = 0; i < 10; i++)
            op('{1'b0, 3, 32'h1400 + 32'(i * 4), $urandom, 4'(i), 32'h0, 0});
        repeat (12) @(negedge clk);
        check("wrap_pulses", 68'(st_pulses - p), 68'd10);
        check("wrap_drained", 68'(exp_q.size()), 68'd0);
        // reset while the first of three queued stores is in flight
        op('{1'b0, 12, 32'h1200, 32'hAAAA0001, 4'hF, 32'h0, 0});
        op('{1'b0, 0,  32'h1204, 32'hAAAA0002, 4'hF, 32'h0, 0});
        op('{1'b0, 0,  32'h1208, 32'hAAAA0003, 4'hF, 32'h0, 0});
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_memwrite", 68'(mem_memwrite), 68'd0);
        check("midrst_memread", 68'(mem_memread), 68'd0);
        check("midrst_addr", 68'(mem_addr), 68'd0);
        check("midrst_wdata", 68'(mem_write_data), 68'd0);
        check("midrst_mask", 68'(mem_sign_mask), 68'd0);
        check("midrst_rdata", 68'(core_read_data), 68'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        p = st_pulses;
        repeat (20) @(negedge clk);
        check("midrst_no_writes", 68'(st_pulses - p), 68'd0);
        op('{1'b1, 0, 32'h1204, 32'h0, 4'hF, 32'h0, 4});
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
